// File: rtl/violin_voice_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// violin_voice_scheduler_pkg
//
// Purpose:
//   Shared widths and types for the violin voice scheduler. It holds the
//   configuration widths (long_percent phase width, audio sample width), the
//   oscillator table-select type and the per-voice playback state. It also
//   provides the helper that turns a voice state into a table select.
//
// Contents:
//   LONG_PERCENT_WIDTH   width of a table address (phase)
//   AUDIO_BIT_WIDTH      width of one table sample
//   DEFAULT_VOICES       default number of voices sharing the table
//   DEFAULT_ACC_W        default phase accumulator width
//   long_percent_t       table address type
//   oscillator_state_t   FRONT / BACK table select
//   voice_state_t        VOICE_IDLE / VOICE_FRONT / VOICE_BACK
//   to_oscillator_state  voice state -> table select (idle reads FRONT)
// ---------------------------------------------------------------------------
package violin_voice_scheduler_pkg;

  localparam int LONG_PERCENT_WIDTH = 16;
  localparam int AUDIO_BIT_WIDTH    = 16;
  localparam int DEFAULT_VOICES     = 4;
  localparam int DEFAULT_ACC_W      = LONG_PERCENT_WIDTH + 8;

  typedef logic [LONG_PERCENT_WIDTH-1:0] long_percent_t;

  typedef enum logic {
    FRONT = 1'b0,
    BACK  = 1'b1
  } oscillator_state_t;

  typedef enum logic [1:0] {
    VOICE_IDLE  = 2'd0,
    VOICE_FRONT = 2'd1,
    VOICE_BACK  = 2'd2
  } voice_state_t;

  // An idle voice still has an address issued for it, so it needs a table
  // select; FRONT is used so the table sees a well-defined request.
  function automatic oscillator_state_t to_oscillator_state(input voice_state_t s);
    return (s == VOICE_BACK) ? BACK : FRONT;
  endfunction

endpackage

// File: rtl/violin_voice_scheduler_voice_state.sv
// ---------------------------------------------------------------------------
// violin_voice_state
//
// Purpose:
//   State and phase accumulator for one voice. FRONT plays the attack table
//   once; the carry out of the accumulator during an update moves the voice
//   to BACK, which then loops until note_off. Note events take effect
//   immediately and override any accumulator update in the same cycle;
//   note_on wins over note_off.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   note_on    in   start / retrigger pulse (voice -> FRONT, acc = 0)
//   note_off   in   stop pulse (voice -> IDLE, acc = 0)
//   update     in   advance the accumulator this cycle (ignored while idle)
//   increment  in   ACC_W-bit phase increment
//   state      out  current voice state
//   phase      out  top LONG_PERCENT_WIDTH bits of the accumulator
//   active     out  1 while the voice is in FRONT or BACK
// ---------------------------------------------------------------------------
module violin_voice_state
  import violin_voice_scheduler_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             note_on,
  input  logic             note_off,
  input  logic             update,
  input  logic [ACC_W-1:0] increment,
  output voice_state_t     state,
  output long_percent_t    phase,
  output logic             active
);

  voice_state_t     state_q;
  voice_state_t     state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  // State and accumulator registers; reset parks the voice idle at phase 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= VOICE_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic. Note events are checked first so they win over the
  // sweep's accumulator update. The extra sum bit is the carry that ends the
  // FRONT segment; the wrapped value is kept so BACK continues seamlessly.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum     = {1'b0, acc_q} + {1'b0, increment};
    if (note_on) begin
      state_d = VOICE_FRONT;
      acc_d   = '0;
    end else if (note_off) begin
      state_d = VOICE_IDLE;
      acc_d   = '0;
    end else if (update && (state_q != VOICE_IDLE)) begin
      acc_d = sum[ACC_W-1:0];
      if ((state_q == VOICE_FRONT) && sum[ACC_W]) begin
        state_d = VOICE_BACK;
      end
    end
  end

  assign state  = state_q;
  assign phase  = acc_q[ACC_W-1 -: LONG_PERCENT_WIDTH];
  assign active = (state_q != VOICE_IDLE);

endmodule

// File: rtl/violin_voice_scheduler.sv
// ---------------------------------------------------------------------------
// violin_voice_scheduler
//
// Purpose:
//   Time-multiplexes one shared violin wavetable (FRONT/BACK tables with a
//   registered read) among VOICES voices. Each sample_tick starts a sweep
//   that presents every voice's address to the table in turn, advances that
//   voice's accumulator, and captures the returned sample one cycle later.
//   sample_valid pulses once all voice_sample entries hold the new set.
//   Idle voices still get an address slot but store 0.
//
// Configuration macro:
//   VIOLIN_SCHED_OVERRUN_EN  adds overrun_count, a saturating count of
//                            sample_tick pulses dropped because a sweep
//                            was still running.
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-high; aborts a running sweep
//   sample_tick   in   1-cycle audio-rate pulse; starts a sweep when idle
//   note_on       in   [VOICES] per-voice start / retrigger pulse
//   note_off      in   [VOICES] per-voice stop pulse
//   increment     in   [VOICES*ACC_W] per-voice phase increments, voice k
//                      at [k*ACC_W +: ACC_W]
//   table_state   out  table select (FRONT/BACK), registered
//   table_phase   out  table address, registered
//   table_sample  in   table data, valid one cycle after the address
//   voice_sample  out  [VOICES*AUDIO_BIT_WIDTH] latest sample per voice,
//                      voice k at [k*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]
//   voice_active  out  [VOICES] voice in FRONT or BACK
//   sample_valid  out  1-cycle pulse: a complete sample set is available
//   busy          out  sweep in progress
//   overrun_count out  (macro only) dropped-tick count, saturating
// ---------------------------------------------------------------------------
module violin_voice_scheduler
  import violin_voice_scheduler_pkg::*;
#(
  parameter int VOICES = DEFAULT_VOICES,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              sample_tick,
  input  logic [VOICES-1:0]                 note_on,
  input  logic [VOICES-1:0]                 note_off,
  input  logic [VOICES*ACC_W-1:0]           increment,
  output oscillator_state_t                 table_state,
  output long_percent_t                     table_phase,
  input  logic [AUDIO_BIT_WIDTH-1:0]        table_sample,
  output logic [VOICES*AUDIO_BIT_WIDTH-1:0] voice_sample,
  output logic [VOICES-1:0]                 voice_active,
  output logic                              sample_valid,
  output logic                              busy
`ifdef VIOLIN_SCHED_OVERRUN_EN
  ,
  output logic [15:0]                       overrun_count
`endif
);

  localparam int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int SLOT_W = $clog2(VOICES + 1);
  localparam logic [SLOT_W-1:0] LAST_ISSUE = SLOT_W'(VOICES - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(VOICES);

  voice_state_t                 v_state [VOICES];
  long_percent_t                v_phase [VOICES];
  logic [VOICES-1:0]            update;
  logic [AUDIO_BIT_WIDTH-1:0]   sample_q [VOICES];

  logic [SLOT_W-1:0]            slot;
  logic                         issue_en;
  logic [IDX_W-1:0]             issue_idx;
  logic [IDX_W-1:0]             cap_idx;
  logic                         pres_idle;
  logic                         cap_idle;

  // One state machine per voice. A voice is updated in the cycle its
  // address sits on the table port (slot k of the sweep), so the address
  // always carries the value from before that update.
  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    violin_voice_state #(
      .ACC_W(ACC_W)
    ) u_voice (
      .clock    (clock),
      .reset    (reset),
      .note_on  (note_on[g]),
      .note_off (note_off[g]),
      .update   (update[g]),
      .increment(increment[g*ACC_W +: ACC_W]),
      .state    (v_state[g]),
      .phase    (v_phase[g]),
      .active   (voice_active[g])
    );

    assign update[g] = busy && (slot == SLOT_W'(g));
    assign voice_sample[g*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH] = sample_q[g];
  end

  // Sweep sequencer. The slot counter runs 0..VOICES while busy: slots
  // 0..VOICES-1 present voices, slots 1..VOICES capture the data coming
  // back, so the final capture lands in slot VOICES and sample_valid follows.
  // Ticks seen while busy are simply not acted on.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy         <= 1'b0;
      slot         <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!busy) begin
        if (sample_tick) begin
          busy <= 1'b1;
          slot <= '0;
        end
      end else if (slot == LAST_SLOT) begin
        busy         <= 1'b0;
        slot         <= '0;
        sample_valid <= 1'b1;
      end else begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

  // Address selection. The table port is registered, so each voice's
  // address is loaded one cycle ahead of its slot: voice 0 on the accepted
  // tick, voice k+1 during slot k.
  always_comb begin
    issue_en  = 1'b0;
    issue_idx = '0;
    if (!busy) begin
      issue_en = sample_tick;
    end else if (slot < LAST_ISSUE) begin
      issue_en  = 1'b1;
      issue_idx = IDX_W'(slot + SLOT_W'(1));
    end
  end

  assign cap_idx = IDX_W'(slot - SLOT_W'(1));

  // Table address registers. Whether the presented voice was idle travels
  // alongside its address so the capture stage knows to store 0 instead of
  // whatever the table returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      table_state <= FRONT;
      table_phase <= '0;
      pres_idle   <= 1'b1;
    end else if (issue_en) begin
      table_state <= to_oscillator_state(v_state[issue_idx]);
      table_phase <= v_phase[issue_idx];
      pres_idle   <= (v_state[issue_idx] == VOICE_IDLE);
    end
  end

  // Capture stage. The table data for the voice presented in slot k arrives
  // in slot k+1; the idle flag is delayed by one cycle to line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_idle <= 1'b1;
      for (int i = 0; i < VOICES; i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      cap_idle <= pres_idle;
      if (busy && (slot != '0)) begin
        sample_q[cap_idx] <= cap_idle ? '0 : table_sample;
      end
    end
  end

`ifdef VIOLIN_SCHED_OVERRUN_EN
  // Dropped-tick counter: counts ticks that arrive while a sweep is still
  // running, and holds at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_count <= '0;
    end else if (sample_tick && busy && (overrun_count != 16'hFFFF)) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_violin_voice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_violin_voice_scheduler
//
// Purpose:
//   Self-checking bench for violin_voice_scheduler (VOICES=4, ACC_W=24,
//   increment = 1<<22 so a voice wraps every 4 sweeps). Each accepted tick
//   pushes a hand-computed sweep record (addresses, table selects, samples,
//   active mask) into a queue; a monitor compares the table port and busy
//   during the sweep and the sample set when sample_valid appears.
//   The table is modelled as a registered read returning
//   {FRONT ? 4'hA : 4'hB, phase[15:4]}.
//   Build with VIOLIN_SCHED_OVERRUN_EN to also check overrun_count.
// ---------------------------------------------------------------------------
module tb_violin_voice_scheduler;
  import violin_voice_scheduler_pkg::*;

  localparam int VOICES = 4;
  localparam int ACC_W  = 24;
  localparam logic [ACC_W-1:0] INC = 24'h400000;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 sample_tick;
  logic [3:0]           note_on;
  logic [3:0]           note_off;
  logic [4*ACC_W-1:0]   increment;
  oscillator_state_t    table_state;
  long_percent_t        table_phase;
  logic [15:0]          table_sample;
  logic [63:0]          voice_sample;
  logic [3:0]           voice_active;
  logic                 sample_valid;
  logic                 busy;
`ifdef VIOLIN_SCHED_OVERRUN_EN
  logic [15:0]          overrun_count;
`endif

  typedef struct {
    int          t;
    logic [63:0] ph;
    logic [3:0]  st;
    logic [63:0] smp;
    logic [3:0]  act;
  } sweep_t;

  sweep_t exp_q[$];
  int     cyc    = 0;
  int     checks = 0;
  int     errors = 0;

  violin_voice_scheduler #(
    .VOICES(VOICES),
    .ACC_W (ACC_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .note_on      (note_on),
    .note_off     (note_off),
    .increment    (increment),
    .table_state  (table_state),
    .table_phase  (table_phase),
    .table_sample (table_sample),
    .voice_sample (voice_sample),
    .voice_active (voice_active),
    .sample_valid (sample_valid),
    .busy         (busy)
`ifdef VIOLIN_SCHED_OVERRUN_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  always #5 clock = ~clock;

  // Cycle counter used to time-stamp ticks and check sweep latency.
  always @(posedge clock) cyc <= cyc + 1;

  // Registered wavetable model.
  function automatic logic [15:0] tableModel(input oscillator_state_t s, input long_percent_t p);
    return {(s == BACK) ? 4'hB : 4'hA, p[15:4]};
  endfunction

  always @(posedge clock) table_sample <= tableModel(table_state, table_phase);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives all control inputs for one cycle, starting just after a rising edge.
  task automatic applyStimulus(input logic [3:0] on, input logic [3:0] off, input logic tick);
    @(posedge clock);
    #1;
    note_on     = on;
    note_off    = off;
    sample_tick = tick;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic pushSweep(input logic [63:0] ph, input logic [3:0] st,
                           input logic [63:0] smp, input logic [3:0] act);
    sweep_t r;
    r.t   = cyc;
    r.ph  = ph;
    r.st  = st;
    r.smp = smp;
    r.act = act;
    exp_q.push_back(r);
  endtask

  task automatic tickSweep(input logic [63:0] ph, input logic [3:0] st,
                           input logic [63:0] smp, input logic [3:0] act);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    pushSweep(ph, st, smp, act);
    idleCycles(VOICES + 5);
  endtask

  // Monitor: compares busy and the table port against the oldest record
  // while its sweep runs, then the sample set when sample_valid arrives.
  always @(negedge clock) begin
    sweep_t r;
    int     k;
    if (!reset) begin
      if (exp_q.size() > 0) begin
        r = exp_q[0];
        if (cyc >= r.t && cyc <= r.t + VOICES + 2)
          checkOutput("busy", 64'(busy), (cyc >= r.t + 1 && cyc <= r.t + VOICES + 1) ? 64'd1 : 64'd0);
        if (cyc >= r.t + 1 && cyc <= r.t + VOICES) begin
          k = cyc - r.t - 1;
          checkOutput($sformatf("table_phase[v%0d]", k), 64'(table_phase), 64'(r.ph[k*16 +: 16]));
          checkOutput($sformatf("table_state[v%0d]", k), 64'(table_state == BACK), 64'(r.st[k]));
        end
        if (sample_valid) begin
          checkOutput("valid_latency", 64'(cyc - r.t), 64'(VOICES + 2));
          checkOutput("voice_sample", voice_sample, r.smp);
          checkOutput("voice_active", 64'(voice_active), 64'(r.act));
          void'(exp_q.pop_front());
        end else if (cyc >= r.t + VOICES + 2) begin
          checkOutput("sample_valid_timeout", 64'(sample_valid), 64'd1);
          void'(exp_q.pop_front());
        end
      end else if (sample_valid) begin
        checkOutput("unexpected_sample_valid", 64'(sample_valid), 64'd0);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    sample_tick = 1'b0;
    note_on     = '0;
    note_off    = '0;
    increment   = {4{INC}};

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_valid", 64'(sample_valid), 64'd0);
    checkOutput("reset_table_state", 64'(table_state), 64'(FRONT));
    checkOutput("reset_table_phase", 64'(table_phase), 64'd0);
    checkOutput("reset_voice_sample", voice_sample, 64'd0);
    checkOutput("reset_voice_active", 64'(voice_active), 64'd0);
`ifdef VIOLIN_SCHED_OVERRUN_EN
    checkOutput("reset_overrun", 64'(overrun_count), 64'd0);
`endif
    reset = 1'b0;
    $display("[TB] reset released");

    // All voices idle: addresses issued, zeros stored.
    tickSweep(64'h0, 4'b0000, 64'h0, 4'b0000);

    // Voice 0 through FRONT and into BACK.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    idleCycles(2);
    checkOutput("active_after_on0", 64'(voice_active), 64'h1);
    tickSweep({16'h0, 16'h0, 16'h0, 16'h0000}, 4'b0000, {16'h0, 16'h0, 16'h0, 16'hA000}, 4'b0001);
    tickSweep({16'h0, 16'h0, 16'h0, 16'h4000}, 4'b0000, {16'h0, 16'h0, 16'h0, 16'hA400}, 4'b0001);
    tickSweep({16'h0, 16'h0, 16'h0, 16'h8000}, 4'b0000, {16'h0, 16'h0, 16'h0, 16'hA800}, 4'b0001);
    tickSweep({16'h0, 16'h0, 16'h0, 16'hC000}, 4'b0000, {16'h0, 16'h0, 16'h0, 16'hAC00}, 4'b0001);
    tickSweep({16'h0, 16'h0, 16'h0, 16'h0000}, 4'b0001, {16'h0, 16'h0, 16'h0, 16'hB000}, 4'b0001);

    // note_off from BACK.
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    idleCycles(1);
    checkOutput("active_after_off0", 64'(voice_active), 64'h0);
    tickSweep(64'h0, 4'b0000, 64'h0, 4'b0000);

    // note_on wins over note_off; retrigger during the present cycle.
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    idleCycles(1);
    checkOutput("active_on_off_same", 64'(voice_active), 64'h6);
    tickSweep({16'h0, 16'h0000, 16'h0000, 16'h0}, 4'b0000, {16'h0, 16'hA000, 16'hA000, 16'h0}, 4'b0110);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    pushSweep({16'h0, 16'h4000, 16'h4000, 16'h0}, 4'b0000, {16'h0, 16'hA400, 16'hA400, 16'h0}, 4'b0110);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    idleCycles(VOICES + 4);
    tickSweep({16'h0, 16'h8000, 16'h0000, 16'h0}, 4'b0000, {16'h0, 16'hA800, 16'hA000, 16'h0}, 4'b0110);

    // Tick at T and T+3: the second one is dropped.
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    pushSweep({16'h0, 16'hC000, 16'h4000, 16'h0}, 4'b0000, {16'h0, 16'hAC00, 16'hA400, 16'h0}, 4'b0110);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    idleCycles(VOICES + 5);
`ifdef VIOLIN_SCHED_OVERRUN_EN
    checkOutput("overrun_count", 64'(overrun_count), 64'd1);
`endif
    tickSweep({16'h0, 16'h0000, 16'h8000, 16'h0}, 4'b0100, {16'h0, 16'hB000, 16'hA800, 16'h0}, 4'b0110);

    // Reset in cycle T+3 aborts the sweep.
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_valid", 64'(sample_valid), 64'd0);
    checkOutput("abort_table_state", 64'(table_state), 64'(FRONT));
    checkOutput("abort_table_phase", 64'(table_phase), 64'd0);
    checkOutput("abort_voice_sample", voice_sample, 64'd0);
    checkOutput("abort_voice_active", 64'(voice_active), 64'd0);
    reset = 1'b0;
    idleCycles(VOICES + 5);
`ifdef VIOLIN_SCHED_OVERRUN_EN
    checkOutput("overrun_after_reset", 64'(overrun_count), 64'd0);
`endif

    // Normal operation after the abort.
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    idleCycles(1);
    tickSweep(64'h0, 4'b0000, {16'hA000, 16'h0, 16'h0, 16'h0}, 4'b1000);

    idleCycles(4);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
